uart_cmd_rx: RTL

UART_CMD_RX -- requirements
Module: uart_cmd_rx

---
 rtl/uart_cmd_rx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that turns each correctly framed byte into a one-cycle
// register write (wdata/we); bad stop bits raise frame_err instead.
module uart_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] wdata,
  output logic       we,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  logic             rx_m;
  logic             rx_s;
  logic [1:0]       sync_valid;
  logic             armed;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [2:0]       idx;
  logic [2:0]       idx_n;
  logic [7:0]       shift;
  logic [7:0]       shift_n;
  logic [7:0]       wdata_n;
  logic             we_n;
  logic             ferr_n;
  logic             busy_n;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // After reset the line must be seen high (once the synchronizer has flushed
  // its reset value) before a start bit is accepted, so a reset in the middle
  // of a frame cannot start on the remaining low data bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_valid <= 2'b00;
      armed      <= 1'b0;
    end else begin
      sync_valid <= {sync_valid[0], 1'b1};
      if (sync_valid[1] && rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      wdata     <= 8'h00;
      we        <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      wdata     <= wdata_n;
      we        <= we_n;
      frame_err <= ferr_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    wdata_n = wdata;
    we_n    = 1'b0;
    ferr_n  = 1'b0;

    if ((state != IDLE) && !en) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en && armed && !rx_s) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt_n   = '0;
            idx_n   = 3'd0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt_n        = '0;
            shift_n[idx] = rx_s;
            if (idx == 3'd7) begin
              state_n = STOP;
            end else begin
              idx_n = idx + 3'd1;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt_n = '0;
            if (rx_s) begin
              state_n = IDLE;
              we_n    = 1'b1;
              wdata_n = shift;
            end else begin
              state_n = WAIT_HIGH;
              ferr_n  = 1'b1;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = 3'd0;
        end
      endcase
    end

    busy_n = (state_n != IDLE);
  end

endmodule
